// File: rtl/aes_pkg.sv
// Shared AES definitions: forward S-box table, GF(2^8) xtime and the
// key-schedule FSM state encoding.
package aes_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DONE} ks_state_t;

    localparam logic [7:0] AES_SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] xtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_key_schedule_seq_if.sv
// Key-schedule request/readback bundle: the master starts an expansion and
// reads round keys by index; the slave is the schedule generator.
interface aes_key_schedule_seq_if #(parameter int NK = 4);

    logic              start_i;
    logic [32*NK-1:0]  key_i;
    logic              busy_o;
    logic              done_o;
    logic              rk_valid_o;
    logic [3:0]        rk_idx_i;
    logic [127:0]      rk_o;

    modport master (output start_i, key_i, rk_idx_i,
                    input  busy_o, done_o, rk_valid_o, rk_o);
    modport slave  (input  start_i, key_i, rk_idx_i,
                    output busy_o, done_o, rk_valid_o, rk_o);

endinterface

// File: rtl/aes_sbox.sv
// Forward AES S-box, one byte, purely combinational table lookup.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);

    assign y = AES_SBOX[a];

endmodule

// File: rtl/aes_key_schedule_seq.sv
// Sequential AES-128/192/256 key expansion: one schedule word per cycle into a
// word register file, round keys read back combinationally by index.
module aes_key_schedule_seq
    import aes_pkg::*;
#(
    parameter int NK = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    aes_key_schedule_seq_if.slave  bus
);

    localparam int NR    = NK + 6;
    localparam int NW    = 4 * (NR + 1);
    localparam int KEY_W = 32 * NK;
    localparam int IDX_W = $clog2(NW);

    if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
        $fatal(1, "aes_key_schedule_seq: NK must be 4, 6 or 8");
    end

    ks_state_t          state, state_nxt;
    logic [IDX_W-1:0]   wi;
    logic [2:0]         phase;      // wi % NK, kept incrementally to avoid a divider
    logic [7:0]         rcon;
    logic [KEY_W-1:0]   key_q;
    logic               done_q;
    logic [31:0]        w [NW];
    logic [31:0]        prev, sub_in, sub_out, temp;
    logic [IDX_W-1:0]   rd_base;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: next-state is assigned a default first so no path through the
    // combinational block leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE: if (bus.start_i) state_nxt = LOAD;
            LOAD:       state_nxt = EXPAND;
            EXPAND:     if (wi == IDX_W'(NW - 1)) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wi     <= '0;
            phase  <= '0;
            rcon   <= 8'h01;
            key_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE, DONE: if (bus.start_i) key_q <= bus.key_i;
                LOAD: begin
                    wi    <= IDX_W'(NK);
                    phase <= '0;
                    rcon  <= 8'h01;
                end
                EXPAND: begin
                    wi    <= wi + IDX_W'(1);
                    phase <= (phase == 3'(NK - 1)) ? 3'd0 : phase + 3'd1;
                    if (phase == 3'd0)        rcon   <= xtime(rcon);
                    if (wi == IDX_W'(NW - 1)) done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // One shared SubWord path; RotWord is applied only on the Rcon words.
    assign prev   = w[wi - IDX_W'(1)];
    assign sub_in = (phase == 3'd0) ? {prev[23:0], prev[31:24]} : prev;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (.a(sub_in[8*b +: 8]), .y(sub_out[8*b +: 8]));
    end

    always_comb begin
        temp = prev;
        if (phase == 3'd0)                  temp = sub_out ^ {rcon, 24'h0};
        else if (NK == 8 && phase == 3'd4)  temp = sub_out;
    end

    // NOTE: the word array has no reset; every word is rewritten during
    // LOAD/EXPAND before rk_valid_o can expose it.
    always_ff @(posedge clk) begin
        if (state == LOAD) begin
            for (int j = 0; j < NK; j++)
                w[IDX_W'(j)] <= key_q[KEY_W - 1 - 32*j -: 32];
        end else if (state == EXPAND) begin
            w[wi] <= w[wi - IDX_W'(NK)] ^ temp;
        end
    end

    assign rd_base = IDX_W'({bus.rk_idx_i, 2'b00});

    always_comb begin
        bus.rk_o = '0;
        if (state == DONE && bus.rk_idx_i <= 4'(NR))
            bus.rk_o = {w[rd_base], w[rd_base + IDX_W'(1)],
                        w[rd_base + IDX_W'(2)], w[rd_base + IDX_W'(3)]};
    end

    assign bus.busy_o     = (state == LOAD) || (state == EXPAND);
    assign bus.done_o     = done_q;
    assign bus.rk_valid_o = (state == DONE);

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Directed bench for the sequential AES key schedule: FIPS-197 key vectors on
// AES-128/192/256 instances, latency, restart, start-while-busy and reset abort.
module tb_aes_key_schedule_seq;

    localparam logic [255:0] KEY_A  = 256'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [255:0] KEY_B  = 256'h0f1571c947d9e8590cb7add6af7f6798;
    localparam logic [255:0] KEY_C  = 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] KEY_D  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_miscmp;

    aes_key_schedule_seq_if #(.NK(4)) bus4 ();
    aes_key_schedule_seq_if #(.NK(6)) bus6 ();
    aes_key_schedule_seq_if #(.NK(8)) bus8 ();

    aes_key_schedule_seq #(.NK(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
    aes_key_schedule_seq #(.NK(6)) u_dut6 (.clk(clk), .rst_n(rst_n), .bus(bus6.slave));
    aes_key_schedule_seq #(.NK(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic get_done(input int nk);
        case (nk)
            6:       return bus6.done_o;
            8:       return bus8.done_o;
            default: return bus4.done_o;
        endcase
    endfunction

    function automatic logic get_busy(input int nk);
        case (nk)
            6:       return bus6.busy_o;
            8:       return bus8.busy_o;
            default: return bus4.busy_o;
        endcase
    endfunction

    function automatic logic get_valid(input int nk);
        case (nk)
            6:       return bus6.rk_valid_o;
            8:       return bus8.rk_valid_o;
            default: return bus4.rk_valid_o;
        endcase
    endfunction

    task automatic set_start(input int nk, input logic s, input logic [255:0] key);
        case (nk)
            6:       begin bus6.start_i = s; bus6.key_i = key[191:0]; end
            8:       begin bus8.start_i = s; bus8.key_i = key;        end
            default: begin bus4.start_i = s; bus4.key_i = key[127:0]; end
        endcase
    endtask

    // Pulses start, then counts edges until done_o. Optionally re-pulses start
    // with key2 at cycle inject_at, or pulls reset low at cycle reset_at.
    task automatic expand(input int nk, input logic [255:0] key,
                          input int inject_at, input logic [255:0] key2, input int reset_at,
                          output int lat, output int done_cnt, output logic valid_after_start,
                          output logic done_tail);
        lat = -1;
        done_cnt = 0;
        done_tail = 1'b0;
        @(negedge clk);
        set_start(nk, 1'b1, key);
        @(posedge clk);
        @(negedge clk);
        set_start(nk, 1'b0, key);
        valid_after_start = get_valid(nk);
        for (int c = 1; c <= 150; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (get_done(nk)) begin
                done_cnt++;
                if (lat < 0) lat = c;
                @(posedge clk);
                @(negedge clk);
                done_tail = get_done(nk);
                break;
            end
            if (c == inject_at)     set_start(nk, 1'b1, key2);
            if (c == inject_at + 1) set_start(nk, 1'b0, key2);
            if (c == reset_at)      rst_n = 1'b0;
            if (c == reset_at + 1) begin
                check("rst_busy",  {127'd0, get_busy(nk)},  128'd0);
                check("rst_valid", {127'd0, get_valid(nk)}, 128'd0);
            end
            if (c == reset_at + 2)  rst_n = 1'b1;
        end
    endtask

    task automatic read_rk(input int nk, input logic [3:0] idx, output logic [127:0] rk);
        @(negedge clk);
        case (nk)
            6:       bus6.rk_idx_i = idx;
            8:       bus8.rk_idx_i = idx;
            default: bus4.rk_idx_i = idx;
        endcase
        #1;
        case (nk)
            6:       rk = bus6.rk_o;
            8:       rk = bus8.rk_o;
            default: rk = bus4.rk_o;
        endcase
    endtask

    initial begin
        int           lat;
        int           dcnt;
        logic         vas;
        logic         tail;
        logic [127:0] rk;

        n_vec    = 0;
        n_miscmp = 0;
        rst_n    = 1'b0;
        set_start(4, 1'b0, '0);
        set_start(6, 1'b0, '0);
        set_start(8, 1'b0, '0);
        bus4.rk_idx_i = '0;
        bus6.rk_idx_i = '0;
        bus8.rk_idx_i = '0;

        #23;
        check("reset_busy",  {127'd0, bus4.busy_o},     128'd0);
        check("reset_done",  {127'd0, bus4.done_o},     128'd0);
        check("reset_valid", {127'd0, bus4.rk_valid_o}, 128'd0);
        check("reset_rk",    bus4.rk_o,                 128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // AES-128, FIPS-197 appendix A.1 key
        expand(4, KEY_A, -10, '0, -10, lat, dcnt, vas, tail);
        check("a128_latency",   128'(lat),  128'd41);
        check("a128_done_tail", {127'd0, tail}, 128'd0);
        check("a128_valid",     {127'd0, bus4.rk_valid_o}, 128'd1);
        read_rk(4, 4'd10, rk);  check("a128_rk10", rk, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        read_rk(4, 4'd1,  rk);  check("a128_rk1",  rk, 128'ha0fafe1788542cb123a339392a6c7605);
        read_rk(4, 4'd11, rk);  check("a128_rk11", rk, 128'd0);

        // Restart from DONE with a second AES-128 key
        expand(4, KEY_B, -10, '0, -10, lat, dcnt, vas, tail);
        check("restart_valid_drop", {127'd0, vas}, 128'd0);
        check("b128_latency", 128'(lat), 128'd41);
        read_rk(4, 4'd0, rk);  check("b128_rk0", rk, KEY_B[127:0]);
        read_rk(4, 4'd1, rk);  check("b128_rk1", rk, 128'hdc9037b09b49dfe997fe723f388115a7);

        // AES-192
        expand(6, KEY_C, -10, '0, -10, lat, dcnt, vas, tail);
        check("a192_latency", 128'(lat), 128'd47);
        read_rk(6, 4'd12, rk);  check("a192_rk12", rk, 128'he98ba06f448c773c8ecc720401002202);
        read_rk(6, 4'd0,  rk);  check("a192_rk0",  rk, 128'h8e73b0f7da0e6452c810f32b809079e5);
        read_rk(6, 4'd13, rk);  check("a192_rk13", rk, 128'd0);

        // AES-256
        expand(8, KEY_D, -10, '0, -10, lat, dcnt, vas, tail);
        check("a256_latency", 128'(lat), 128'd53);
        read_rk(8, 4'd14, rk);  check("a256_rk14", rk, 128'hfe4890d1e6188d0b046df344706c631e);
        read_rk(8, 4'd1,  rk);  check("a256_rk1",  rk, 128'h1f352c073b6108d72d9810a30914dff4);
        read_rk(8, 4'd15, rk);  check("a256_rk15", rk, 128'd0);

        // start_i while busy must be ignored
        expand(4, KEY_A, 20, KEY_B, -10, lat, dcnt, vas, tail);
        check("inject_latency", 128'(lat), 128'd41);
        read_rk(4, 4'd10, rk);  check("inject_rk10", rk, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        read_rk(4, 4'd0,  rk);  check("inject_rk0",  rk, KEY_A[127:0]);

        // Reset mid-expansion: no done_o, then a clean restart
        expand(4, KEY_B, -10, '0, 15, lat, dcnt, vas, tail);
        check("rst_done_cnt", 128'(dcnt), 128'd0);
        check("rst_post_busy",  {127'd0, bus4.busy_o},     128'd0);
        check("rst_post_valid", {127'd0, bus4.rk_valid_o}, 128'd0);
        read_rk(4, 4'd10, rk);  check("rst_post_rk", rk, 128'd0);
        expand(4, KEY_A, -10, '0, -10, lat, dcnt, vas, tail);
        check("rst_restart_latency", 128'(lat), 128'd41);
        read_rk(4, 4'd10, rk);  check("rst_restart_rk10", rk, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        read_rk(4, 4'd11, rk);  check("rst_restart_rk11", rk, 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
